dct_1d_stream: RTL and testbench
================================

Name: dct_1d_stream

Overview:
- Parametrised successor to the fixed 8-point DCT core: a 1-D N-point DCT-II over a stream of unsigned pixel samples.
- Supports N = 4 or 8, configurable input/output widths, optional level shift, and valid/ready handshakes on both sides with output backpressure.
- Sits between the pixel reader and the row/column transpose buffer; one invocation transforms one N-sample vector.
- Serial MAC architecture: one multiply-accumulate per cycle.

Parameters:
- N, 8, transform length; only 4 and 8 are legal, other values are an elaboration error.
- DATA_W, 8, unsigned input sample width.
- OUT_W, 32, signed coefficient output and accumulator width.
- LEVEL_SHIFT, 1, when 1 subtract 2^(DATA_W-1) from each sample before the MAC; when 0 zero-extend the sample.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a new vector; sampled only in IDLE
- data_in  in  DATA_W  unsigned sample
- in_valid  in  1  data_in valid
- in_ready  out  1  block can accept a sample
- data_out  out  OUT_W  signed DCT coefficient X[k]
- out_index  out  3  k of the current data_out (upper bits 0 when N=4)
- out_valid  out  1  data_out/out_index valid
- out_ready  in  1  consumer accepts data_out
- busy  out  1  high in every state except IDLE
- finish  out  1  one-cycle pulse after X[N-1] is accepted

Behaviour:
- Reset (synchronous, highest priority, any state): state=IDLE; in_ready, out_valid, busy and finish are 0; data_out, out_index, accumulator, sample buffer and counters are 0. Reset mid-vector discards the vector with no output.
- States: IDLE, LOAD, CALC, EMIT, DONE.
- IDLE: start=1 -> LOAD. While busy, start is ignored.
- LOAD: in_ready=1. Each cycle with in_valid&&in_ready stores buf[n] = shifted sample and increments n. Accepting sample N-1 -> CALC with k=0.
- LOAD, shifted sample: signed, DATA_W+1 bits. LEVEL_SHIFT=1 gives data_in - 2^(DATA_W-1); LEVEL_SHIFT=0 gives {0,data_in}.
- CALC: N cycles. Cycle n computes acc += buf[n]*C[k][n]. acc is cleared at the first CALC cycle of each k. The product is sign-extended to OUT_W; accumulation wraps mod 2^OUT_W with no saturation. After cycle N-1 -> EMIT.
- EMIT: out_valid=1, data_out=acc, out_index=k, all held stable until out_ready=1.
  - On out_valid&&out_ready with k<N-1: k++ -> CALC.
  - On out_valid&&out_ready with k=N-1: -> DONE.
- DONE: finish=1 for exactly one cycle -> IDLE. A start in the DONE cycle is ignored; start is honoured from the following cycle.
- Latency: the first out_valid rises N+1 cycles after the edge that accepts the last sample. Each further coefficient takes N+1 cycles if out_ready is held at 1. Total for N=8 with no stalls: 8 load + 8*9 + 1 = 81 cycles.
- Coefficients: C[k][n] = round(4096*c(k)*cos((2n+1)k*pi/(2N))), where c(0)=sqrt(1/N) and c(k>0)=sqrt(2/N). Stored as 13-bit signed ROM constants.
- N=8 magnitudes: k0 1448; cos(pi/16) 2009, cos(2pi/16) 1892, cos(3pi/16) 1703, cos(4pi/16) 1448, cos(5pi/16) 1138, cos(6pi/16) 784, cos(7pi/16) 400. Signs follow the cosine.
- N=4 magnitudes: k0 2048, k1 2676/1108, k2 2048.
- in_valid outside LOAD is ignored. out_ready outside EMIT is ignored.

Test Plan:
- N=8, LEVEL_SHIFT=1, out_ready=1; 8 samples of 200 -> X0=834048 (8*72*1448), X1..X7=0; out_index 0..7; finish pulses once.
- N=8 impulse: samples 129,128,128,128,128,128,128,128 -> X0..X7 = 1448,2009,1892,1703,1448,1138,784,400.
- N=4, LEVEL_SHIFT=0; 4 samples of 1 -> X0=8192, X1=0, X2=0, X3=0; first out_valid exactly 5 cycles after the last accept.
- Backpressure: out_ready=0 for 10 cycles at k=2 -> data_out and out_index=2 held stable; no duplicate or lost coefficient; total length grows by 10 cycles.
- in_valid gaps during LOAD (every other cycle) -> identical results; start asserted during CALC -> ignored.
- Reset pulse during CALC at k=3 -> next cycle busy=0, out_valid=0; a fresh vector afterwards produces correct results with no stale output.

Source files
------------

// File: rtl/dct_1d_stream.sv
// Streaming 1-D N-point DCT-II (N = 4 or 8) with a serial MAC.
// Samples load into a buffer, then each X[k] is accumulated over N cycles.
module dct_1d_stream #(
    parameter int N           = 8,
    parameter int DATA_W      = 8,
    parameter int OUT_W       = 32,
    parameter int LEVEL_SHIFT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  data_out,
    output logic [2:0]        out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              finish
);

    localparam int IW = (N == 8) ? 3 : 2;
    localparam int PW = DATA_W + 14;
    localparam logic [DATA_W:0] HALF = {2'b01, {(DATA_W-1){1'b0}}};

    if (!(N == 4 || N == 8)) begin : g_bad_n
        $error("dct_1d_stream: N must be 4 or 8");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_EMIT,
        S_DONE
    } state_t;

    // Coefficient for row k, column n. The angle (2n+1)k*pi/(2N) is folded
    // into the first quadrant by symmetry so one small magnitude table serves.
    function automatic logic signed [12:0] coef_f(input int kk, input int nn);
        int  m;
        int  mag;
        logic neg;
        m = ((2 * nn + 1) * kk) % (4 * N);
        if (m > 2 * N) m = 4 * N - m;
        neg = (m > N);
        if (neg) m = 2 * N - m;
        mag = 0;
        if (kk == 0) begin
            mag = (N == 8) ? 1448 : 2048;
        end else if (N == 8) begin
            case (m)
                1: mag = 2009;
                2: mag = 1892;
                3: mag = 1703;
                4: mag = 1448;
                5: mag = 1138;
                6: mag = 784;
                7: mag = 400;
                default: mag = 0;
            endcase
        end else begin
            case (m)
                1: mag = 2676;
                2: mag = 2048;
                3: mag = 1108;
                default: mag = 0;
            endcase
        end
        return neg ? 13'(-mag) : 13'(mag);
    endfunction

    logic signed [12:0] rom [N*N];

    for (genvar gk = 0; gk < N; gk++) begin : g_rom_k
        for (genvar gn = 0; gn < N; gn++) begin : g_rom_n
            assign rom[gk*N+gn] = coef_f(gk, gn);
        end
    end

    state_t                   state_q, state_d;
    logic [IW-1:0]            n_q, n_d;
    logic [IW-1:0]            k_q, k_d;
    logic signed [OUT_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W:0]   samp_q [N];
    logic signed [DATA_W:0]   samp_d [N];
    logic [OUT_W-1:0]         data_out_q, data_out_d;
    logic [2:0]               out_index_q, out_index_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     busy_q, busy_d;
    logic                     finish_q, finish_d;

    logic signed [DATA_W:0]   samp_in;
    logic signed [12:0]       coef_sel;
    logic signed [PW-1:0]     prod;
    logic signed [OUT_W-1:0]  prod_ext;
    logic signed [OUT_W-1:0]  acc_base;

    // Level-shift the incoming sample and form the current MAC product.
    always_comb begin
        if (LEVEL_SHIFT != 0) begin
            samp_in = {1'b0, data_in} - HALF;
        end else begin
            samp_in = {1'b0, data_in};
        end
        coef_sel = rom[{k_q, n_q}];
        prod     = PW'(samp_q[n_q]) * PW'(coef_sel);
        prod_ext = OUT_W'(prod);
        acc_base = (n_q == '0) ? '0 : acc_q;
    end

    // Next-state logic; outputs are derived from the next state so they are registered.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        k_d         = k_q;
        acc_d       = acc_q;
        samp_d      = samp_q;
        data_out_d  = data_out_q;
        out_index_d = out_index_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    n_d     = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    samp_d[n_q] = samp_in;
                    if (n_q == IW'(N - 1)) begin
                        state_d = S_CALC;
                        n_d     = '0;
                        k_d     = '0;
                    end else begin
                        n_d = n_q + IW'(1);
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_base + prod_ext;
                if (n_q == IW'(N - 1)) begin
                    state_d     = S_EMIT;
                    n_d         = '0;
                    data_out_d  = acc_d;
                    out_index_d = 3'(k_q);
                end else begin
                    n_d = n_q + IW'(1);
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (k_q == IW'(N - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + IW'(1);
                        state_d = S_CALC;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d  = (state_d == S_LOAD);
        out_valid_d = (state_d == S_EMIT);
        busy_d      = (state_d != S_IDLE);
        finish_d    = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            for (int i = 0; i < N; i++) begin
                samp_q[i] <= '0;
            end
            data_out_q  <= '0;
            out_index_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            samp_q      <= samp_d;
            data_out_q  <= data_out_d;
            out_index_q <= out_index_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            finish_q    <= finish_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign out_index = out_index_q;
    assign busy      = busy_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_dct_1d_stream.sv
// Bench for dct_1d_stream: an N=8 level-shifted core and an N=4 unshifted core
// checked against a floating-point DCT-II model with rounded coefficients.
module tb_dct_1d_stream;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] start_s, in_valid_s, in_ready_s;
    logic [1:0] out_valid_s, out_ready_s, busy_s, finish_s;
    logic [1:0][7:0]  din_s;
    logic [1:0][31:0] dout_s;
    logic [1:0][2:0]  oidx_s;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    dct_1d_stream #(.N(8), .DATA_W(8), .OUT_W(32), .LEVEL_SHIFT(1)) u_dut8 (
        .clk(clk), .reset(rst), .start(start_s[0]), .data_in(din_s[0]),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .data_out(dout_s[0]), .out_index(oidx_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .busy(busy_s[0]), .finish(finish_s[0])
    );

    dct_1d_stream #(.N(4), .DATA_W(8), .OUT_W(32), .LEVEL_SHIFT(0)) u_dut4 (
        .clk(clk), .reset(rst), .start(start_s[1]), .data_in(din_s[1]),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .data_out(dout_s[1]), .out_index(oidx_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .busy(busy_s[1]), .finish(finish_s[1])
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        vec_cnt++;
        if (obs != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_coef(input int nn, input int k, input int n);
        real c;
        real v;
        c = (k == 0) ? $sqrt(1.0 / nn) : $sqrt(2.0 / nn);
        v = 4096.0 * c * $cos((2 * n + 1) * k * PI / (2.0 * nn));
        return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
    endfunction

    task automatic run_vec(input int d, input int nn, input int ls,
                           input int smp[8], input bit gaps,
                           input int stall_k, input int stall_len,
                           input bit start_mid, input int abort_k);
        int exp_x[8];
        int sent, got, cyc, acc_cyc, first_ov;
        int stalls, busy_cnt, fin_cnt, load_cnt;
        longint s;
        for (int k = 0; k < nn; k++) begin
            s = 0;
            for (int n = 0; n < nn; n++) begin
                s += longint'(ls != 0 ? smp[n] - 128 : smp[n]) * ref_coef(nn, k, n);
            end
            exp_x[k] = int'(s);
        end
        sent = 0; got = 0; cyc = 0; acc_cyc = 0; first_ov = -1;
        stalls = 0; busy_cnt = 0; fin_cnt = 0; load_cnt = 0;
        start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
        while (got < nn && cyc < 600) begin
            cyc++;
            busy_cnt += int'(busy_s[d]);
            fin_cnt  += int'(finish_s[d]);
            load_cnt += int'(in_ready_s[d]);
            if (first_ov < 0 && out_valid_s[d] && sent == nn) begin
                first_ov = cyc - acc_cyc;
                chk("first_ov_latency", first_ov, nn + 1);
            end
            if (abort_k >= 0 && got == abort_k && !out_valid_s[d] && sent == nn) begin
                rst = 1'b1;
                in_valid_s[d] = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                out_ready_s[d] = 1'b1;
                chk("abort_busy", busy_s[d], 0);
                chk("abort_out_valid", out_valid_s[d], 0);
                chk("abort_data_out", dout_s[d], 0);
                chk("abort_finish", finish_s[d], 0);
                @(negedge clk);
                return;
            end
            if (out_valid_s[d]) begin
                chk("data_out", $signed(dout_s[d]), exp_x[got]);
                chk("out_index", oidx_s[d], got);
                if (got == stall_k && stalls < stall_len) begin
                    out_ready_s[d] = 1'b0;
                    stalls++;
                end else begin
                    out_ready_s[d] = 1'b1;
                    got++;
                end
            end else begin
                out_ready_s[d] = 1'($urandom_range(0, 1));
            end
            if (sent < nn && in_ready_s[d] && !(gaps && cyc % 2 == 1)) begin
                in_valid_s[d] = 1'b1;
                din_s[d] = 8'(smp[sent]);
                sent++;
                if (sent == nn) acc_cyc = cyc;
            end else begin
                in_valid_s[d] = (sent == nn) ? 1'($urandom_range(0, 1)) : 1'b0;
                din_s[d] = 8'($urandom_range(0, 255));
            end
            start_s[d] = start_mid && sent == nn && cyc == acc_cyc + 2;
            @(negedge clk);
        end
        chk("coef_count", got, nn);
        start_s[d] = 1'b0;
        in_valid_s[d] = 1'b0;
        busy_cnt += int'(busy_s[d]);
        chk("finish_early", fin_cnt, 0);
        chk("finish_pulse", finish_s[d], 1);
        chk("busy_total", busy_cnt, load_cnt + nn * (nn + 1) + 1 + stall_len);
        start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
        chk("finish_one_cycle", finish_s[d], 0);
        chk("start_in_done_ignored", busy_s[d], 0);
        @(negedge clk);
    endtask

    initial begin
        int smp[8];
        rst = 1'b1;
        start_s = '0;
        in_valid_s = '0;
        out_ready_s = 2'b11;
        din_s = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy", busy_s[d], 0);
            chk("reset_in_ready", in_ready_s[d], 0);
            chk("reset_out_valid", out_valid_s[d], 0);
            chk("reset_finish", finish_s[d], 0);
            chk("reset_data_out", dout_s[d], 0);
            chk("reset_out_index", oidx_s[d], 0);
        end

        for (int i = 0; i < 8; i++) smp[i] = 200;
        run_vec(0, 8, 1, smp, 1'b0, -1, 0, 1'b0, -1);

        smp[0] = 129;
        for (int i = 1; i < 8; i++) smp[i] = 128;
        run_vec(0, 8, 1, smp, 1'b0, -1, 0, 1'b0, -1);

        for (int i = 0; i < 8; i++) smp[i] = 1;
        run_vec(1, 4, 0, smp, 1'b0, -1, 0, 1'b0, -1);

        for (int i = 0; i < 8; i++) smp[i] = int'($urandom_range(0, 255));
        run_vec(0, 8, 1, smp, 1'b0, 2, 10, 1'b0, -1);

        for (int i = 0; i < 8; i++) smp[i] = int'($urandom_range(0, 255));
        run_vec(0, 8, 1, smp, 1'b1, -1, 0, 1'b1, -1);

        for (int i = 0; i < 8; i++) smp[i] = int'($urandom_range(0, 255));
        run_vec(0, 8, 1, smp, 1'b0, -1, 0, 1'b0, 3);
        for (int i = 0; i < 8; i++) smp[i] = int'($urandom_range(0, 255));
        run_vec(0, 8, 1, smp, 1'b0, -1, 0, 1'b0, -1);

        for (int r = 0; r < 12; r++) begin
            int d;
            int nn;
            d  = r % 2;
            nn = (d == 0) ? 8 : 4;
            for (int i = 0; i < 8; i++) smp[i] = int'($urandom_range(0, 255));
            run_vec(d, nn, (d == 0) ? 1 : 0, smp, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, nn - 1)), int'($urandom_range(0, 5)),
                    1'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
